// File: rtl/core_sequencer_pkg.sv
// ============================================================================
// Module  : core_sequencer_pkg
// Brief   : State encoding and trap cause codes shared by the core sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HALTED    = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    localparam logic [3:0] c_FETCH_FAULT = 4'd1;
    localparam logic [3:0] c_ILLEGAL     = 4'd2;
    localparam logic [3:0] c_BREAKPOINT  = 4'd3;
    localparam logic [3:0] c_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] c_STORE_FAULT = 4'd7;
    localparam logic [3:0] c_ECALL_M     = 4'd11;

    function automatic logic [3:0] mem_fault_cause(input logic is_load);
        return is_load ? c_LOAD_FAULT : c_STORE_FAULT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_sequencer_watchdog.sv
// ============================================================================
// Module  : core_sequencer_watchdog
// Brief   : Wait-cycle counter; flags expiry after WATCHDOG_CYCLES idle cycles.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module core_sequencer_watchdog #(
    parameter int unsigned WATCHDOG_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_waiting,
    output logic o_expired
);

    localparam int unsigned c_W =
        ($clog2(WATCHDOG_CYCLES + 1) < 8) ? 8 : $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [c_W-1:0] c_LIMIT = c_W'(WATCHDOG_CYCLES - 1);

    logic [c_W-1:0] r_count;

    // Any cycle that is not a wait cycle (handshake or other state) restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_waiting) begin
            r_count <= r_count + c_W'(1);
        end else begin
            r_count <= '0;
        end
    end

    assign o_expired = i_waiting && (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// ============================================================================
// Module  : core_sequencer
// Brief   : Multi-cycle RV32I control FSM with instruction register and retire
//           counter. Optional wait timeout: CORE_SEQUENCER_WATCHDOG_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module core_sequencer #(
    parameter int unsigned WATCHDOG_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    output logic        halted,
    output logic        fetchRequest,
    input  logic        fetchValid,
    input  logic        fetchError,
    input  logic [31:0] fetchData,
    output logic [31:0] currentInstruction,
    output logic        isNOP,
    input  logic [4:0]  rdIndex,
    input  logic        invalidInstruction,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic        isBranch,
    input  logic        isFence,
    input  logic        isECALL,
    input  logic        isEBREAK,
    output logic        memRequest,
    input  logic        memAck,
    input  logic        memError,
    output logic        executeStrobe,
    output logic        pcUpdate,
    output logic        regWrite,
    output logic        trapRequest,
    output logic [3:0]  trapCause,
    output logic [31:0] retiredCount
);

    import core_sequencer_pkg::*;

    state_t      r_state;
    logic [31:0] r_instr;
    logic [3:0]  r_cause;
    logic [31:0] r_retired;
    logic        w_wd_expired;

`ifdef CORE_SEQUENCER_WATCHDOG_EN
    logic w_waiting;

    assign w_waiting = ((r_state == ST_FETCH)  && !fetchValid && !fetchError) ||
                       ((r_state == ST_MEMORY) && !memAck     && !memError);

    core_sequencer_watchdog #(
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_waiting (w_waiting),
        .o_expired (w_wd_expired)
    );
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (WATCHDOG_CYCLES == 0);
    assign w_wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_HALTED;
            r_instr   <= '0;
            r_cause   <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                ST_HALTED: begin
                    if (!halt) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    // A bus error beats a simultaneous valid beat.
                    if (fetchError || w_wd_expired) begin
                        r_cause <= c_FETCH_FAULT;
                        r_state <= ST_TRAP;
                    end else if (fetchValid) begin
                        r_instr <= fetchData;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (invalidInstruction) begin
                        r_cause <= c_ILLEGAL;
                        r_state <= ST_TRAP;
                    end else if (isEBREAK) begin
                        r_cause <= c_BREAKPOINT;
                        r_state <= ST_TRAP;
                    end else if (isECALL) begin
                        r_cause <= c_ECALL_M;
                        r_state <= ST_TRAP;
                    end else begin
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    r_state <= (isLoad || isStore) ? ST_MEMORY : ST_WRITEBACK;
                end
                ST_MEMORY: begin
                    if (memError || w_wd_expired) begin
                        r_cause <= mem_fault_cause(isLoad);
                        r_state <= ST_TRAP;
                    end else if (memAck) begin
                        r_state <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    r_retired <= r_retired + 32'd1;
                    r_state   <= halt ? ST_HALTED : ST_FETCH;
                end
                ST_TRAP: begin
                    r_state <= halt ? ST_HALTED : ST_FETCH;
                end
                default: begin
                    r_state <= ST_HALTED;
                end
            endcase
        end
    end

    assign halted             = (r_state == ST_HALTED);
    assign fetchRequest       = (r_state == ST_FETCH);
    assign memRequest         = (r_state == ST_MEMORY);
    assign executeStrobe      = (r_state == ST_EXECUTE);
    assign pcUpdate           = (r_state == ST_WRITEBACK);
    assign trapRequest        = (r_state == ST_TRAP);
    assign isNOP              = (r_state == ST_HALTED) || (r_state == ST_FETCH) ||
                                (r_state == ST_TRAP);
    assign regWrite           = (r_state == ST_WRITEBACK) && (rdIndex != 5'd0) &&
                                !(isBranch || isStore || isFence);
    assign currentInstruction = r_instr;
    assign trapCause          = r_cause;
    assign retiredCount       = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// ============================================================================
// Module  : tb_core_sequencer
// Brief   : Instruction-table bench for core_sequencer with a small decoder
//           model and a completion scoreboard.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b1;
    logic        halted;
    logic        fetchRequest;
    logic        fetchValid = 1'b0;
    logic        fetchError = 1'b0;
    logic [31:0] fetchData = '0;
    logic [31:0] currentInstruction;
    logic        isNOP;
    logic [4:0]  rdIndex;
    logic        invalidInstruction, isLoad, isStore, isBranch, isFence, isECALL, isEBREAK;
    logic        memRequest;
    logic        memAck = 1'b0;
    logic        memError = 1'b0;
    logic        executeStrobe, pcUpdate, regWrite, trapRequest;
    logic [3:0]  trapCause;
    logic [31:0] retiredCount;

    always #5 clk = ~clk;

    core_sequencer #(.WATCHDOG_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .halted(halted),
        .fetchRequest(fetchRequest), .fetchValid(fetchValid), .fetchError(fetchError),
        .fetchData(fetchData), .currentInstruction(currentInstruction), .isNOP(isNOP),
        .rdIndex(rdIndex), .invalidInstruction(invalidInstruction), .isLoad(isLoad),
        .isStore(isStore), .isBranch(isBranch), .isFence(isFence), .isECALL(isECALL),
        .isEBREAK(isEBREAK), .memRequest(memRequest), .memAck(memAck), .memError(memError),
        .executeStrobe(executeStrobe), .pcUpdate(pcUpdate), .regWrite(regWrite),
        .trapRequest(trapRequest), .trapCause(trapCause), .retiredCount(retiredCount)
    );

    // Minimal RV32I decoder standing in for the real decode block.
    logic [6:0] w_op;
    assign w_op               = currentInstruction[6:0];
    assign rdIndex            = currentInstruction[11:7];
    assign isLoad             = (w_op == 7'b0000011);
    assign isStore            = (w_op == 7'b0100011);
    assign isBranch           = (w_op == 7'b1100011);
    assign isFence            = (w_op == 7'b0001111);
    assign isECALL            = (currentInstruction == 32'h0000_0073);
    assign isEBREAK           = (currentInstruction == 32'h0010_0073);
    assign invalidInstruction = !(w_op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                               7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                               7'b0010111, 7'b0001111, 7'b1110011});

    typedef struct {
        logic [31:0] instr;
        int          fetch_wait;
        logic        fetch_err;
        int          mem_wait;
        logic        mem_ack;
        logic        mem_err;
        logic        halt_in_mem;
        logic        preset;
        logic        exp_trap;
        logic [3:0]  exp_cause;
        logic        exp_regw;
        int          exp_len;
        int          exp_exec;
        int          exp_memreq;
        logic        exp_halt_after;
        int          start;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    vec_t        sb[$];
    logic [31:0] model_retired = '0;
    int          n_exec = 0;
    int          n_mem = 0;
    logic        next_pending = 1'b0;
    logic        nx_halt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic [31:0] i, int fw, logic fe, int mw, logic ma, logic me,
                                logic hm, logic pr, logic t, logic [3:0] c, logic rw,
                                int len, int ex, int mr, logic ha);
        vec_t v;
        v.instr = i; v.fetch_wait = fw; v.fetch_err = fe; v.mem_wait = mw; v.mem_ack = ma;
        v.mem_err = me; v.halt_in_mem = hm; v.preset = pr; v.exp_trap = t; v.exp_cause = c;
        v.exp_regw = rw; v.exp_len = len; v.exp_exec = ex; v.exp_memreq = mr;
        v.exp_halt_after = ha; v.start = 0;
        return v;
    endfunction

    // Scoreboard side: every pcUpdate/trapRequest retires one expected record.
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (rst_n) begin
            if (next_pending) begin
                next_pending = 1'b0;
                check("next_fetchRequest", {31'd0, fetchRequest}, {31'd0, !nx_halt});
                check("next_halted", {31'd0, halted}, {31'd0, nx_halt});
            end
            if (executeStrobe) n_exec++;
            if (memRequest) n_mem++;
            if (pcUpdate || trapRequest) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("trapRequest", {31'd0, trapRequest}, {31'd0, e.exp_trap});
                    check("pcUpdate", {31'd0, pcUpdate}, {31'd0, !e.exp_trap});
                    if (e.exp_trap) check("trapCause", {28'd0, trapCause}, {28'd0, e.exp_cause});
                    check("regWrite", {31'd0, regWrite}, {31'd0, e.exp_regw});
                    check("latency", 32'(cyc - e.start + 1), 32'(e.exp_len));
                    check("executeStrobe_cycles", 32'(n_exec), 32'(e.exp_exec));
                    check("memRequest_cycles", 32'(n_mem), 32'(e.exp_memreq));
                    check("retiredCount", retiredCount, model_retired);
                    if (!e.exp_trap) model_retired = model_retired + 32'd1;
                    next_pending = 1'b1;
                    nx_halt = e.exp_halt_after;
                end
                n_exec = 0;
                n_mem = 0;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int n;
        n = 0;
        while (!fetchRequest && n < 20) begin @(negedge clk); n++; end
        if (!fetchRequest) begin
            check("fetch_start_timeout", 32'd1, 32'd0);
            return;
        end
        v.start = cyc;
        repeat (v.fetch_wait) @(negedge clk);
        fetchValid = 1'b1; fetchError = v.fetch_err; fetchData = v.instr;
        sb.push_back(v);
        @(negedge clk);
        fetchValid = 1'b0; fetchError = 1'b0; fetchData = '0;
        if (v.exp_memreq > 0) begin
            n = 0;
            while (!memRequest && n < 5) begin @(negedge clk); n++; end
            if (!memRequest) check("mem_start_timeout", 32'd1, 32'd0);
            if (v.preset) begin
                force dut.r_retired = 32'hFFFF_FFFF;
                model_retired = 32'hFFFF_FFFF;
            end
            if (v.halt_in_mem) halt = 1'b1;
            repeat (v.mem_wait) @(negedge clk);
            if (v.preset) release dut.r_retired;
            memAck = v.mem_ack; memError = v.mem_err;
            @(negedge clk);
            memAck = 1'b0; memError = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 12) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            check("completion_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        //           instr        fw fe mw ma me hm pr  trap cause rw len ex mr ha
        vecs.push_back(mk(32'h0010_0093, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0,  1, 4, 1, 0, 0)); // ADDI x1
        vecs.push_back(mk(32'h0011_2023, 0, 0, 3, 1, 0, 0, 0, 0, 4'd0,  0, 8, 1, 4, 0)); // SW
        vecs.push_back(mk(32'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 1, 4'd2,  0, 3, 0, 0, 0)); // compressed
        vecs.push_back(mk(32'h0000_A103, 0, 0, 0, 1, 1, 0, 0, 1, 4'd5,  0, 5, 1, 1, 0)); // LW ack+err
        vecs.push_back(mk(32'h0010_0093, 2, 1, 0, 0, 0, 0, 0, 1, 4'd1,  0, 4, 0, 0, 0)); // fetch error
        vecs.push_back(mk(32'h0010_0073, 0, 0, 0, 0, 0, 0, 0, 1, 4'd3,  0, 3, 0, 0, 0)); // EBREAK
        vecs.push_back(mk(32'h0000_0073, 0, 0, 0, 0, 0, 0, 0, 1, 4'd11, 0, 3, 0, 0, 0)); // ECALL
        vecs.push_back(mk(32'h0020_8463, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0,  0, 5, 1, 0, 0)); // BEQ
        vecs.push_back(mk(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0,  0, 4, 1, 0, 0)); // ADDI x0
        vecs.push_back(mk(32'h0000_A103, 0, 0, 1, 1, 0, 0, 0, 0, 4'd0,  1, 6, 1, 2, 0)); // LW x2
        vecs.push_back(mk(32'h0011_2023, 0, 0, 0, 0, 1, 0, 0, 1, 4'd7,  0, 5, 1, 1, 0)); // SW error
        vecs.push_back(mk(32'h0FF0_000F, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0,  0, 4, 1, 0, 0)); // FENCE
        vecs.push_back(mk(32'h0011_2023, 0, 0, 2, 1, 0, 1, 1, 0, 4'd0,  0, 7, 1, 3, 1)); // SW + halt + wrap

        repeat (2) @(negedge clk);
        check("rst_halted", {31'd0, halted}, 32'd1);
        check("rst_isNOP", {31'd0, isNOP}, 32'd1);
        check("rst_currentInstruction", currentInstruction, 32'd0);
        check("rst_retiredCount", retiredCount, 32'd0);
        check("rst_trapCause", {28'd0, trapCause}, 32'd0);
        check("rst_requests", {26'd0, fetchRequest, memRequest, executeStrobe, pcUpdate,
                               regWrite, trapRequest}, 32'd0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_halted", {31'd0, halted}, 32'd1);
        halt = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        repeat (3) @(negedge clk);
        check("halt_stays_halted", {31'd0, halted}, 32'd1);
        check("halt_no_fetch", {31'd0, fetchRequest}, 32'd0);
        check("retired_wrapped", retiredCount, 32'd0);

`ifdef CORE_SEQUENCER_WATCHDOG_EN
        begin
            vec_t w;
            int n;
            halt = 1'b0;
            n = 0;
            while (!fetchRequest && n < 5) begin @(negedge clk); n++; end
            w = mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd1, 0, 5, 0, 0, 0);
            w.start = cyc;
            sb.push_back(w);
            n = 0;
            while (sb.size() != 0 && n < 12) begin @(negedge clk); n++; end
            if (sb.size() != 0) begin
                check("watchdog_timeout", 32'd1, 32'd0);
                sb.delete();
            end
            @(negedge clk);
        end
`endif

        halt = 1'b0;
        begin
            int n;
            n = 0;
            while (!fetchRequest && n < 10) begin @(negedge clk); n++; end
        end
        check("midfetch_in_fetch", {31'd0, fetchRequest}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midfetch_reset_fetchRequest", {31'd0, fetchRequest}, 32'd0);
        check("midfetch_reset_halted", {31'd0, halted}, 32'd1);
        check("midfetch_reset_retired", retiredCount, 32'd0);
        halt = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
